// File: rtl/dmem_pkg.sv
// Shared encodings and types for the dmem_lsu data-memory slice.
package dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} dmem_size_t;

endpackage

// File: rtl/dmem_align.sv
// Combinational width decode: store lane steering, load extract/extend, error flag.
// Error detection is compiled in with DMEM_LSU_ERR_EN; otherwise addresses are truncated.
module dmem_align
  import dmem_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  dmem_size_t  sz;
  logic        uns;
  logic        illegal;
  logic [1:0]  off;
  logic [15:0] lo16;

  // Width/sign decode; illegal encodings collapse to a plain word access
  always_comb begin
    sz      = SZ_W;
    uns     = 1'b0;
    illegal = 1'b0;
    case (funct3_i)
      F3_LB:   sz = SZ_B;
      F3_LH:   sz = SZ_H;
      F3_LW:   sz = SZ_W;
      F3_LBU:  begin sz = SZ_B; uns = 1'b1; illegal = we_i; end
      F3_LHU:  begin sz = SZ_H; uns = 1'b1; illegal = we_i; end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      sz  = SZ_W;
      uns = 1'b0;
    end
  end

`ifdef DMEM_LSU_ERR_EN
  logic misal;
  always_comb begin
    misal = ((sz == SZ_H) && addr_lo_i[0]) || ((sz == SZ_W) && (addr_lo_i != 2'b00));
    err_o = illegal | misal;
    off   = addr_lo_i;
  end
`else
  always_comb begin
    err_o = 1'b0;
    case (sz)
      SZ_B:    off = addr_lo_i;
      SZ_H:    off = {addr_lo_i[1], 1'b0};
      default: off = 2'b00;
    endcase
  end
`endif

  always_comb begin
    lo16 = 16'(rword_i >> {off, 3'b000});
    case (sz)
      SZ_B: begin
        be_o    = 4'b0001 << off;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{~uns & lo16[7]}}, lo16[7:0]};
      end
      SZ_H: begin
        be_o    = 4'b0011 << off;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{~uns & lo16[15]}}, lo16};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rword_i;
      end
    endcase
    if (err_o) be_o = 4'b0000;
    if (err_o || we_i) rdata_o = 32'h0;
  end

endmodule

// File: rtl/dmem_lsu.sv
// Single-outstanding data memory with RISC-V width decode and configurable load latency.
// Optional error reporting enabled by DMEM_LSU_ERR_EN.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 11,
  parameter int unsigned ADDR_W     = DEPTH_LOG2 + 2,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LAT   = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                                  (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  logic [31:0] mem_q [DEPTH];

  dmem_state_t state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] rd_q, rd_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic                  accept;
  logic [DEPTH_LOG2-1:0] widx;
  logic [3:0]            be;
  logic [31:0]           wdata_sh;
  logic [31:0]           rdata_ext;
  logic                  err;

  assign accept    = req_valid && (state_q == IDLE);
  assign widx      = req_addr[ADDR_W-1:2];
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  dmem_align u_align (
    .we_i      (req_we),
    .funct3_i  (req_funct3),
    .addr_lo_i (req_addr[1:0]),
    .wdata_i   (req_wdata),
    .rword_i   (mem_q[widx]),
    .be_o      (be),
    .wdata_o   (wdata_sh),
    .rdata_o   (rdata_ext),
    .err_o     (err)
  );

  // Store commits on the accept edge; error accesses arrive with be == 0
  always_ff @(posedge clk) begin
    if (accept && req_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[widx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      rd_q        <= 32'h0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Load data is sampled at accept and parked in rd_q until the latency expires
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rsp_err_d = err;
          if (req_we || err || (LAT == 1)) begin
            state_d     = RESP;
            rsp_rdata_d = rdata_ext;
          end else begin
            state_d = WAIT;
            cnt_d   = 2'(LAT - 1);
            rd_d    = rdata_ext;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 2'd1) begin
          state_d     = RESP;
          rsp_rdata_d = rd_q;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu (RD_LAT = 3); covers DMEM_LSU_ERR_EN both ways.
module tb_dmem_lsu;

  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [12:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;

  dmem_lsu #(.RD_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, wait for the response and check its latency; leaves the bench in RESP
  task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                       input logic [12:0] addr, input logic [31:0] wd, input logic exp_err);
    int cyc;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    chk({tag, "/req_ready"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    req_addr  = ~addr;
    req_wdata = ~wd;
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({tag, "/latency"}, 32'(cyc), (we || exp_err) ? 32'd1 : 32'(LAT));
  endtask

  task automatic op(input string tag, input logic we, input logic [2:0] f3,
                    input logic [12:0] addr, input logic [31:0] wd,
                    input logic [31:0] exp_data, input logic exp_err);
    issue(tag, we, f3, addr, wd, exp_err);
    chk({tag, "/rdata"}, rsp_rdata, exp_data);
    chk({tag, "/err"}, 32'(rsp_err), 32'(exp_err));
    tick();
    chk({tag, "/done"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 13'h0;
    req_wdata  = 32'h0;
    rsp_ready  = 1'b1;
    tick();
    tick();
    chk("rst/rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst/rsp_rdata", rsp_rdata, 32'h0);
    chk("rst/rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst/req_ready", 32'(req_ready), 32'd1);

    // Word store/load and byte extraction
    op("sw10", 1'b1, 3'b010, 13'h010, 32'h11223344, 32'h0, 1'b0);
    op("lw10", 1'b0, 3'b010, 13'h010, 32'h0, 32'h11223344, 1'b0);
    op("lb13", 1'b0, 3'b000, 13'h013, 32'h0, 32'h00000011, 1'b0);
    op("lbu10", 1'b0, 3'b100, 13'h010, 32'h0, 32'h00000044, 1'b0);
    op("lh12", 1'b0, 3'b001, 13'h012, 32'h0, 32'h00001122, 1'b0);

    // Half and byte stores leave other lanes alone
    op("sw20", 1'b1, 3'b010, 13'h020, 32'h00000000, 32'h0, 1'b0);
    op("sh22", 1'b1, 3'b001, 13'h022, 32'hDEAD8000, 32'h0, 1'b0);
    op("lh22", 1'b0, 3'b001, 13'h022, 32'h0, 32'hFFFF8000, 1'b0);
    op("lhu22", 1'b0, 3'b101, 13'h022, 32'h0, 32'h00008000, 1'b0);
    op("lw20", 1'b0, 3'b010, 13'h020, 32'h0, 32'h80000000, 1'b0);
    op("sb21", 1'b1, 3'b000, 13'h021, 32'h123456A5, 32'h0, 1'b0);
    op("lw20b", 1'b0, 3'b010, 13'h020, 32'h0, 32'h8000A500, 1'b0);
    op("lb21", 1'b0, 3'b000, 13'h021, 32'h0, 32'hFFFFFFA5, 1'b0);
    op("lbu23", 1'b0, 3'b100, 13'h023, 32'h0, 32'h00000080, 1'b0);

    op("sw30", 1'b1, 3'b010, 13'h030, 32'h12345678, 32'h0, 1'b0);
`ifdef DMEM_LSU_ERR_EN
    op("sw31err", 1'b1, 3'b010, 13'h031, 32'hFFFFFFFF, 32'h0, 1'b1);
    op("lw30", 1'b0, 3'b010, 13'h030, 32'h0, 32'h12345678, 1'b0);
    op("f3_011", 1'b0, 3'b011, 13'h030, 32'h0, 32'h0, 1'b1);
    op("lh31err", 1'b0, 3'b001, 13'h031, 32'h0, 32'h0, 1'b1);
    op("sbu_err", 1'b1, 3'b100, 13'h030, 32'h01020304, 32'h0, 1'b1);
    op("lw30b", 1'b0, 3'b010, 13'h030, 32'h0, 32'h12345678, 1'b0);
`else
    op("sw31trunc", 1'b1, 3'b010, 13'h031, 32'hCAFEBABE, 32'h0, 1'b0);
    op("lw30", 1'b0, 3'b010, 13'h030, 32'h0, 32'hCAFEBABE, 1'b0);
    op("lh33trunc", 1'b0, 3'b001, 13'h033, 32'h0, 32'hFFFFCAFE, 1'b0);
    op("f3_011", 1'b0, 3'b011, 13'h030, 32'h0, 32'hCAFEBABE, 1'b0);
    op("sbu_as_sw", 1'b1, 3'b100, 13'h030, 32'h01020304, 32'h0, 1'b0);
    op("lw30b", 1'b0, 3'b010, 13'h030, 32'h0, 32'h01020304, 1'b0);
`endif

    // Response backpressure: outputs frozen while rsp_ready is low
    rsp_ready = 1'b0;
    issue("bp", 1'b0, 3'b010, 13'h010, 32'h0, 1'b0);
    held = rsp_rdata;
    chk("bp/rdata", held, 32'h11223344);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp/valid_hold", 32'(rsp_valid), 32'd1);
      chk("bp/rdata_hold", rsp_rdata, 32'h11223344);
      chk("bp/err_hold", 32'(rsp_err), 32'd0);
      chk("bp/req_ready_low", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp/released", 32'(rsp_valid), 32'd0);
    chk("bp/req_ready", 32'(req_ready), 32'd1);

    // Reset one cycle after a load accept drops the load
    op("sw40", 1'b1, 3'b010, 13'h040, 32'h5A5A5A5A, 32'h0, 1'b0);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 13'h040;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rstw/in_wait", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    tick();
    chk("rstw/valid_in_rst", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    tick();
    chk("rstw/req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstw/no_rsp", 32'(rsp_valid), 32'd0);
    end

    // Store accepted just before reset stays committed
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 13'h044;
    req_wdata  = 32'h0BADF00D;
    tick();
    req_valid = 1'b0;
    chk("rsts/in_resp", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    tick();
    chk("rsts/dropped", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    tick();
    op("lw44", 1'b0, 3'b010, 13'h044, 32'h0, 32'h0BADF00D, 1'b0);
    op("lw40", 1'b0, 3'b010, 13'h040, 32'h0, 32'h5A5A5A5A, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised data memory with a single-outstanding request/response handshake, RISC-V load/store width decode, and a configurable read latency. It generalises the core's byte-enable data memory with sub-word store lane steering and load sign/zero extension, so the LSU stage issues raw `funct3` plus a byte address. It also adds misalignment/illegal-access error reporting and response backpressure. It sits between the core's memory stage and on-chip data RAM.

## Interface
- `DEPTH_LOG2`, default 11: log2 of the number of 32-bit words.
- `ADDR_W`, default `DEPTH_LOG2+2`: byte-address width. Fixed relation; no out-of-range addresses exist.
- `RD_LAT`, default 1: load latency in cycles, legal range 1..4.
- `clk` input 1: the single clock.
- `rst` input 1: reset, asynchronous and active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request.
- `req_we` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RISC-V width/sign field.
- `req_addr` input `ADDR_W`: byte address.
- `req_wdata` input 32: store data, right-aligned.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: consumer takes the response.
- `rsp_rdata` output 32: extended load data; 0 for stores and errors.
- `rsp_err` output 1: misaligned access or illegal `funct3`.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - `req_ready` = (state == IDLE).
  - `rsp_valid` = (state == RESP).
- Accept = `req_valid & req_ready`. Request fields are sampled only on accept.
- Legal `funct3` values:
  - Loads: LB=000, LH=001, LW=010, LBU=100, LHU=101.
  - Stores: SB=000, SH=001, SW=010.
  - Every other value is illegal.
- Misaligned cases: H with `addr[0]`=1; W with `addr[1:0]`≠0.
- Store lanes, with word index `addr[ADDR_W-1:2]`:
  - SB writes lane `addr[1:0]` with `wdata[7:0]`.
  - SH writes lanes {`addr[1]`*2, +1} with `wdata[15:0]`.
  - SW writes all four lanes.
  - Unselected lanes are unchanged.
- Load extraction:
  - The selected byte/half is shifted to bit 0.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Store or error on accept: go to RESP.
- Load on accept:
  - If `RD_LAT`=1, go to RESP.
  - Otherwise go to WAIT with a counter of `RD_LAT-1`. WAIT decrements the counter and moves to RESP when it reaches 1.
- RESP holds `rsp_valid`, `rsp_rdata` and `rsp_err` stable until `rsp_ready`, then returns to IDLE.
- Error access: memory is untouched, `rsp_err`=1, `rsp_rdata`=0.
- Memory contents are not reset. The simulation initial value is all-zero.

## Timing
- Reset values:
  - state = IDLE
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0
  - `req_ready`=1 once reset is deasserted.
- Store write commits at the accept edge T. `rsp_valid`=1 from cycle T+1.
- Load word read is sampled at the accept edge T. `rsp_valid` and data appear at T+`RD_LAT`.
- Only one request is outstanding at a time. The minimum issue interval is `RD_LAT`+1 cycles when `rsp_ready` is held high.
- A load issued after a store response to the same word returns the new data.
- `rsp_ready` low in RESP stalls indefinitely, with no output change.
- `rsp_ready` outside RESP is ignored.
- Reset during WAIT or RESP:
  - The load is dropped, with no response.
  - An accepted store has already committed and stays committed.
- No combinational path from `req_*` to `rsp_*`. `req_ready` depends only on state.

## Configuration
- Macro `DMEM_LSU_ERR_EN`.
- Defined: misalignment and illegal `funct3` are detected as above, stores are suppressed, and `rsp_err` is driven.
- Undefined:
  - `rsp_err` is tied 0.
  - Address low bits are truncated to natural alignment: H ignores `addr[0]`; W ignores `addr[1:0]`.
  - Illegal `funct3` values are treated as LW/SW.

## Structure
- Package `dmem_pkg` holds:
  - `localparam` encodings for `funct3` (LB, LH, LW, LBU, LHU).
  - Enum typedef `dmem_state_t` (IDLE, WAIT, RESP).
  - The `RD_LAT` legal bounds.
- Sub-module `dmem_align`, purely combinational, provides:
  - Store byte-enable and lane-shifted write data.
  - Load extract/extend.
  - The error flag.
- The top level holds the memory array, the read-data delay register, the counter and the FSM.

## Test plan
- SW 0x11223344 @0x10, then LW @0x10 → `rsp_rdata`=0x11223344, `rsp_err`=0, with latency `RD_LAT`.
- After the previous step, LB @0x13 → 0x00000011. LBU @0x10 → 0x00000044.
- SH 0x8000 @0x22, then LH @0x22 → 0xFFFF8000; LHU @0x22 → 0x00008000; LW @0x20 → 0x80000000.
- With `DMEM_LSU_ERR_EN` defined:
  - SW @0x31 → `rsp_err`=1, and a following LW @0x30 returns the prior contents.
  - `funct3`=011 → `rsp_err`=1.
- Load with `rsp_ready` held low for 5 cycles → outputs stable, `req_ready`=0 throughout. Response completes on the first cycle `rsp_ready`=1.
- `RD_LAT`=3: assert `rst` one cycle after a load accept → no `rsp_valid`, `req_ready`=1 after release. A store accepted before reset remains readable.
